// File: rtl/snd_cmd_mailbox.sv
// Main-to-sound CPU command mailbox: DEPTH-entry FIFO or single overwrite latch,
// with a stretched NMI request and a reply latch back to the main CPU.
module snd_cmd_mailbox #(
  parameter int DW         = 8,
  parameter int DEPTH      = 4,
  parameter int NMI_CYCLES = 3,
  parameter int QUEUE_MODE = 1
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          main_cen,
  input  logic          main_wr,
  input  logic [DW-1:0] main_din,
  output logic          main_full,
  output logic [DW-1:0] main_reply,
  input  logic          snd_cen,
  input  logic          snd_rd,
  output logic [DW-1:0] snd_dout,
  output logic          snd_pending,
  output logic          snd_nmi,
  input  logic          snd_reply_wr,
  input  logic [DW-1:0] snd_reply_din,
  output logic          overflow,
  input  logic          ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] latch_q, latch_d;
  logic [7:0]    nmi_cnt_q, nmi_cnt_d;
  logic          full_q, full_d, pending_q, pending_d, nmi_q, nmi_d, ovf_q, ovf_d;
  logic [DW-1:0] dout_q, dout_d, reply_q, reply_d;
  logic          push, pop, push_ok, ovf_set, nmi_load;

  always_comb begin
    push      = main_cen & main_wr;
    pop       = snd_cen & snd_rd & pending_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    latch_d   = latch_q;
    push_ok   = 1'b0;
    ovf_set   = 1'b0;
    nmi_load  = 1'b0;
    pending_d = pending_q;
    full_d    = 1'b0;
    dout_d    = '0;

    if (QUEUE_MODE != 0) begin
      // A full queue still accepts a push when a pop frees a slot in the same cycle
      push_ok  = push & ((count_q != CW'(DEPTH)) | pop);
      ovf_set  = push & ~push_ok;
      nmi_load = push_ok;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d   = count_q + CW'(push_ok) - CW'(pop);
      pending_d = (count_d != '0);
      full_d    = (count_d == CW'(DEPTH));
      // Show-ahead head: bypass the incoming byte when it lands in the new head slot
      if (count_d == '0)
        dout_d = '0;
      else if (push_ok && (wr_ptr_q == rd_ptr_d))
        dout_d = main_din;
      else
        dout_d = mem_q[rd_ptr_d];
    end else begin
      ovf_set   = push & pending_q;
      nmi_load  = push & (main_din != latch_q);
      if (push) latch_d = main_din;
      pending_d = push | (pending_q & ~pop);
      dout_d    = latch_d;
    end

    if (nmi_load)
      nmi_cnt_d = 8'(NMI_CYCLES);
    else if (snd_cen && (nmi_cnt_q != 8'd0))
      nmi_cnt_d = nmi_cnt_q - 8'd1;
    else
      nmi_cnt_d = nmi_cnt_q;
    nmi_d = (nmi_cnt_d != 8'd0);

    ovf_d   = ovf_set | (ovf_q & ~ovf_clr);
    reply_d = (snd_cen & snd_reply_wr) ? snd_reply_din : reply_q;
  end

  always_ff @(posedge clk_sys) begin
    if (push_ok) mem_q[wr_ptr_q] <= main_din;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      latch_q   <= '0;
      nmi_cnt_q <= '0;
      full_q    <= 1'b0;
      pending_q <= 1'b0;
      nmi_q     <= 1'b0;
      ovf_q     <= 1'b0;
      dout_q    <= '0;
      reply_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      latch_q   <= latch_d;
      nmi_cnt_q <= nmi_cnt_d;
      full_q    <= full_d;
      pending_q <= pending_d;
      nmi_q     <= nmi_d;
      ovf_q     <= ovf_d;
      dout_q    <= dout_d;
      reply_q   <= reply_d;
    end
  end

  assign main_full   = full_q;
  assign main_reply  = reply_q;
  assign snd_dout    = dout_q;
  assign snd_pending = pending_q;
  assign snd_nmi     = nmi_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_snd_cmd_mailbox.sv
// Directed bench for snd_cmd_mailbox: one queue-mode and one latch-mode instance
// sharing clock and reset.
module tb_snd_cmd_mailbox;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;

  logic       q_main_cen = 0, q_main_wr = 0, q_snd_cen = 0, q_snd_rd = 0;
  logic       q_snd_reply_wr = 0, q_ovf_clr = 0;
  logic [7:0] q_main_din = 0, q_snd_reply_din = 0;
  logic       q_main_full, q_snd_pending, q_snd_nmi, q_overflow;
  logic [7:0] q_main_reply, q_snd_dout;

  logic       l_main_cen = 0, l_main_wr = 0, l_snd_cen = 0, l_snd_rd = 0;
  logic       l_snd_reply_wr = 0, l_ovf_clr = 0;
  logic [7:0] l_main_din = 0, l_snd_reply_din = 0;
  logic       l_main_full, l_snd_pending, l_snd_nmi, l_overflow;
  logic [7:0] l_main_reply, l_snd_dout;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk_sys = ~clk_sys;

  snd_cmd_mailbox #(.DW(8), .DEPTH(4), .NMI_CYCLES(3), .QUEUE_MODE(1)) dutQueue (
    .clk_sys(clk_sys), .reset(reset),
    .main_cen(q_main_cen), .main_wr(q_main_wr), .main_din(q_main_din),
    .main_full(q_main_full), .main_reply(q_main_reply),
    .snd_cen(q_snd_cen), .snd_rd(q_snd_rd), .snd_dout(q_snd_dout),
    .snd_pending(q_snd_pending), .snd_nmi(q_snd_nmi),
    .snd_reply_wr(q_snd_reply_wr), .snd_reply_din(q_snd_reply_din),
    .overflow(q_overflow), .ovf_clr(q_ovf_clr)
  );

  snd_cmd_mailbox #(.DW(8), .DEPTH(4), .NMI_CYCLES(3), .QUEUE_MODE(0)) dutLatch (
    .clk_sys(clk_sys), .reset(reset),
    .main_cen(l_main_cen), .main_wr(l_main_wr), .main_din(l_main_din),
    .main_full(l_main_full), .main_reply(l_main_reply),
    .snd_cen(l_snd_cen), .snd_rd(l_snd_rd), .snd_dout(l_snd_dout),
    .snd_pending(l_snd_pending), .snd_nmi(l_snd_nmi),
    .snd_reply_wr(l_snd_reply_wr), .snd_reply_din(l_snd_reply_din),
    .overflow(l_overflow), .ovf_clr(l_ovf_clr)
  );

  // Inputs change and outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    assertCount++;
    if ({q_main_full, q_snd_pending, q_snd_nmi, q_overflow} !== 4'b0) begin
      failCount++;
      $display("[TB] FAIL reset_q_flags got %b want 0000", {q_main_full, q_snd_pending, q_snd_nmi, q_overflow});
    end
    assertCount++;
    if ({q_snd_dout, q_main_reply} !== 16'h0) begin
      failCount++;
      $display("[TB] FAIL reset_q_data got %h want 0000", {q_snd_dout, q_main_reply});
    end
    assertCount++;
    if ({l_main_full, l_snd_pending, l_snd_nmi, l_overflow, l_snd_dout, l_main_reply} !== 20'h0) begin
      failCount++;
      $display("[TB] FAIL reset_l_all got %h want 00000",
               {l_main_full, l_snd_pending, l_snd_nmi, l_overflow, l_snd_dout, l_main_reply});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fifo_order();
    logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
    q_snd_cen  = 1'b1;
    q_main_cen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      q_main_wr  = 1'b1;
      q_main_din = exp[i];
      tick();
    end
    q_main_wr = 1'b0;
    assertCount++;
    if (q_snd_pending !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL order_pending got %b want 1", q_snd_pending);
    end
    for (int i = 0; i < 3; i++) begin
      assertCount++;
      if (q_snd_dout !== exp[i]) begin
        failCount++;
        $display("[TB] FAIL order_head%0d got %h want %h", i, q_snd_dout, exp[i]);
      end
      q_snd_rd = 1'b1;
      tick();
      q_snd_rd = 1'b0;
    end
    assertCount++;
    if ({q_snd_pending, q_snd_dout} !== 9'h0) begin
      failCount++;
      $display("[TB] FAIL order_empty got %h want 000", {q_snd_pending, q_snd_dout});
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      q_main_wr  = 1'b1;
      q_main_din = 8'hA0 + 8'(i);
      tick();
      if (i == 3) begin
        assertCount++;
        if ({q_main_full, q_overflow} !== 2'b10) begin
          failCount++;
          $display("[TB] FAIL ovf_full4 got full/ovf %b want 10", {q_main_full, q_overflow});
        end
      end
    end
    q_main_wr = 1'b0;
    assertCount++;
    if ({q_main_full, q_overflow} !== 2'b11) begin
      failCount++;
      $display("[TB] FAIL ovf_drop got full/ovf %b want 11", {q_main_full, q_overflow});
    end
    for (int i = 0; i < 4; i++) begin
      assertCount++;
      if (q_snd_dout !== 8'hA0 + 8'(i)) begin
        failCount++;
        $display("[TB] FAIL ovf_head%0d got %h want %h", i, q_snd_dout, 8'hA0 + 8'(i));
      end
      q_snd_rd = 1'b1;
      tick();
      q_snd_rd = 1'b0;
    end
    assertCount++;
    if ({q_snd_pending, q_main_full, q_overflow} !== 3'b001) begin
      failCount++;
      $display("[TB] FAIL ovf_drained got pend/full/ovf %b want 001", {q_snd_pending, q_main_full, q_overflow});
    end
    q_ovf_clr = 1'b1;
    tick();
    q_ovf_clr = 1'b0;
    assertCount++;
    if (q_overflow !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL ovf_clear got %b want 0", q_overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] model [$];
    for (int i = 0; i < 4; i++) begin
      q_main_wr  = 1'b1;
      q_main_din = 8'hB0 + 8'(i);
      model.push_back(q_main_din);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      q_main_wr  = 1'b1;
      q_snd_rd   = 1'b1;
      q_main_din = 8'h55 + 8'(i);
      void'(model.pop_front());
      model.push_back(q_main_din);
      tick();
      assertCount++;
      if ({q_main_full, q_overflow, q_snd_dout} !== {2'b10, model[0]}) begin
        failCount++;
        $display("[TB] FAIL b2b_iter%0d got full/ovf/dout %b/%b/%h want 1/0/%h",
                 i, q_main_full, q_overflow, q_snd_dout, model[0]);
      end
    end
    q_main_wr = 1'b0;
    q_snd_rd  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      assertCount++;
      if (q_snd_dout !== model[0]) begin
        failCount++;
        $display("[TB] FAIL b2b_drain%0d got %h want %h", i, q_snd_dout, model[0]);
      end
      void'(model.pop_front());
      q_snd_rd = 1'b1;
      tick();
      q_snd_rd = 1'b0;
    end
    assertCount++;
    if (q_snd_pending !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL b2b_empty got %b want 0", q_snd_pending);
    end
  endtask

  // Push at c=0 and again at c=8 (after two snd_cen ticks); snd_cen every 4th cycle
  task automatic test_nmi();
    logic exp;
    tick();
    tick();
    assertCount++;
    if (q_snd_nmi !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL nmi_idle got %b want 0", q_snd_nmi);
    end
    for (int c = 0; c < 24; c++) begin
      q_snd_cen  = ((c % 4) == 3);
      q_main_wr  = (c == 0) || (c == 8);
      q_main_din = (c == 0) ? 8'h01 : 8'h02;
      tick();
      exp = (c <= 18);
      assertCount++;
      if (q_snd_nmi !== exp) begin
        failCount++;
        $display("[TB] FAIL nmi_cycle%0d got %b want %b", c, q_snd_nmi, exp);
      end
    end
    q_main_wr = 1'b0;
    q_snd_cen = 1'b1;
    for (int i = 0; i < 2; i++) begin
      assertCount++;
      if (q_snd_dout !== 8'(i + 1)) begin
        failCount++;
        $display("[TB] FAIL nmi_head%0d got %h want %h", i, q_snd_dout, 8'(i + 1));
      end
      q_snd_rd = 1'b1;
      tick();
      q_snd_rd = 1'b0;
    end
  endtask

  task automatic test_latch();
    l_snd_cen  = 1'b1;
    l_main_cen = 1'b1;
    l_main_wr  = 1'b1;
    l_main_din = 8'h07;
    tick();
    l_main_wr = 1'b0;
    assertCount++;
    if ({l_snd_nmi, l_snd_pending, l_overflow, l_snd_dout} !== {3'b110, 8'h07}) begin
      failCount++;
      $display("[TB] FAIL latch_first got nmi/pend/ovf/dout %b%b%b/%h want 110/07",
               l_snd_nmi, l_snd_pending, l_overflow, l_snd_dout);
    end
    tick();
    tick();
    tick();
    assertCount++;
    if (l_snd_nmi !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL latch_nmi_end got %b want 0", l_snd_nmi);
    end
    l_main_wr = 1'b1;
    tick();
    assertCount++;
    if ({l_snd_nmi, l_overflow} !== 2'b01) begin
      failCount++;
      $display("[TB] FAIL latch_same got nmi/ovf %b want 01", {l_snd_nmi, l_overflow});
    end
    l_main_din = 8'h09;
    tick();
    l_main_wr = 1'b0;
    assertCount++;
    if ({l_snd_nmi, l_snd_pending, l_main_full, l_snd_dout} !== {3'b110, 8'h09}) begin
      failCount++;
      $display("[TB] FAIL latch_third got nmi/pend/full/dout %b%b%b/%h want 110/09",
               l_snd_nmi, l_snd_pending, l_main_full, l_snd_dout);
    end
    l_main_wr  = 1'b1;
    l_snd_rd   = 1'b1;
    l_main_din = 8'h0A;
    tick();
    l_main_wr = 1'b0;
    assertCount++;
    if ({l_snd_pending, l_snd_dout} !== {1'b1, 8'h0A}) begin
      failCount++;
      $display("[TB] FAIL latch_push_pop got pend/dout %b/%h want 1/0a", l_snd_pending, l_snd_dout);
    end
    tick();
    l_snd_rd = 1'b0;
    assertCount++;
    if ({l_snd_pending, l_snd_dout} !== {1'b0, 8'h0A}) begin
      failCount++;
      $display("[TB] FAIL latch_pop got pend/dout %b/%h want 0/0a", l_snd_pending, l_snd_dout);
    end
  endtask

  task automatic test_reply_reset();
    q_snd_cen       = 1'b1;
    q_snd_reply_wr  = 1'b1;
    q_snd_reply_din = 8'hC3;
    tick();
    q_snd_reply_wr = 1'b0;
    assertCount++;
    if (q_main_reply !== 8'hC3) begin
      failCount++;
      $display("[TB] FAIL reply_write got %h want c3", q_main_reply);
    end
    q_snd_cen       = 1'b0;
    q_snd_reply_wr  = 1'b1;
    q_snd_reply_din = 8'h3C;
    tick();
    q_snd_reply_wr = 1'b0;
    q_snd_cen      = 1'b1;
    assertCount++;
    if (q_main_reply !== 8'hC3) begin
      failCount++;
      $display("[TB] FAIL reply_no_cen got %h want c3", q_main_reply);
    end
    for (int i = 0; i < 3; i++) begin
      q_main_wr  = 1'b1;
      q_main_din = 8'hD1 + 8'(i);
      tick();
    end
    q_main_wr = 1'b0;
    assertCount++;
    if ({q_snd_pending, q_snd_nmi, q_snd_dout} !== {2'b11, 8'hD1}) begin
      failCount++;
      $display("[TB] FAIL pre_reset got pend/nmi/dout %b%b/%h want 11/d1", q_snd_pending, q_snd_nmi, q_snd_dout);
    end
    reset = 1'b1;
    tick();
    assertCount++;
    if ({q_main_full, q_snd_pending, q_snd_nmi, q_overflow, q_snd_dout, q_main_reply} !== 20'h0) begin
      failCount++;
      $display("[TB] FAIL mid_reset got %h want 00000",
               {q_main_full, q_snd_pending, q_snd_nmi, q_overflow, q_snd_dout, q_main_reply});
    end
    reset = 1'b0;
    tick();
    assertCount++;
    if (q_snd_pending !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL post_reset_pending got %b want 0", q_snd_pending);
    end
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_overflow();
    test_back_to_back();
    test_nmi();
    test_latch();
    test_reply_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/snd_cmd_mailbox.md
Name: snd_cmd_mailbox

Overview:
Parametrised command channel from the main CPU to the sound CPU, with a reply latch in the return direction.
It generalises the single sound latch with change-detect NMI into two modes: a DEPTH-entry FIFO, or a single overwrite latch.
NMI pulse length counts sound-side clock enables, so both CPUs run on clk_sys and are qualified by their own enables.
It sits between the main CPU port decoder (write strobe at the sound port) and the sound CPU address decoder (command read window, NMI input).

Parameters:
DW, 8, command/reply data width in bits.
DEPTH, 4, FIFO entries in queue mode; power of two, >=2; ignored in latch mode.
NMI_CYCLES, 3, snd_nmi high time in snd_cen ticks; range 1..255.
QUEUE_MODE, 1, 1 = FIFO queue; 0 = single latch, change-detect NMI.

Ports:
clk_sys  in  1  system clock; the only clock.
reset  in  1  synchronous, active-high reset.
main_cen  in  1  main CPU clock enable; qualifies main_wr.
main_wr  in  1  main CPU write strobe to the command port.
main_din  in  DW  command byte.
main_full  out  1  queue full (queue mode); always 0 in latch mode.
main_reply  out  DW  last value written by the sound CPU.
snd_cen  in  1  sound CPU clock enable; qualifies snd_rd, snd_reply_wr and NMI countdown.
snd_rd  in  1  sound CPU read of command port; pops in queue mode.
snd_dout  out  DW  head entry (show-ahead) or latch value.
snd_pending  out  1  unread command present.
snd_nmi  out  1  NMI request to sound CPU, active high.
snd_reply_wr  in  1  sound CPU write to reply latch.
snd_reply_din  in  DW  reply byte.
overflow  out  1  sticky: a command was dropped because the queue was full.
ovf_clr  in  1  clears overflow (one clk_sys cycle).

Behaviour:
- Reset: every output is 0.
  - Queue pointers, count, NMI counter, latch and reply are all 0.
  - Reset mid-operation discards all queued commands and ends any active NMI in the next cycle.
- Accepted push = main_cen & main_wr.
- Accepted pop = snd_cen & snd_rd & snd_pending.
- All outputs are registered. A push in cycle N gives snd_pending, snd_dout and snd_nmi updated in cycle N+1.
- Queue mode (QUEUE_MODE=1):
  - Circular buffer, log2(DEPTH)-bit pointers, count 0..DEPTH.
  - Pointers wrap from DEPTH-1 to 0.
  - snd_dout = mem[rd_ptr] when count>0, else 0.
  - snd_pending = (count != 0); main_full = (count == DEPTH).
  - Push while full and no pop that cycle: data is dropped, overflow set, pointers unchanged.
  - Push and pop in the same cycle while full: both happen; count stays DEPTH; no overflow.
  - Push and pop in the same cycle while empty: only the push takes effect (pop is not accepted because pending=0).
  - Pop while empty: ignored.
- Latch mode (QUEUE_MODE=0):
  - Every push overwrites the latch; snd_dout = latch.
  - snd_pending is set on push and cleared on pop. Push and pop in the same cycle leave pending = 1.
  - overflow is set when a push arrives while pending = 1 (unread value overwritten).
- NMI:
  - Queue mode: each accepted (non-dropped) push loads the counter with NMI_CYCLES.
  - Latch mode: a push loads the counter only if main_din != the current latch.
  - The counter retriggers (reloads) on a qualifying push, even when already running.
  - snd_nmi = (counter != 0). The counter decrements by 1 on each snd_cen while nonzero.
  - If a load and an snd_cen coincide, the load wins.
- Reply latch: main_reply <= snd_reply_din on snd_cen & snd_reply_wr; visible the next cycle; holds until the next write or reset.
- overflow:
  - Set has priority over ovf_clr in the same cycle.
  - Cleared only by ovf_clr or reset.

Test Plan:
1. Queue mode, DEPTH=4: push 0x11,0x22,0x33 with no pops.
   -> snd_pending=1, snd_dout=0x11.
   -> Pops return 0x11, 0x22, 0x33 in order; snd_pending=0 after the third pop.
2. Queue mode: push 5 values (0xA0..0xA4).
   -> main_full=1 after the 4th; 0xA4 dropped; overflow=1.
   -> Pops yield 0xA0..0xA3.
   -> Then ovf_clr -> overflow=0.
3. Full queue, simultaneous push 0x55 and pop.
   -> count stays 4, overflow stays 0.
   -> 0x55 is read after the 3 older entries.
   -> Repeat 8 times to exercise pointer wrap.
4. NMI_CYCLES=3, snd_cen every 4th clk_sys: push 0x01.
   -> snd_nmi high from N+1 for exactly 3 snd_cen ticks.
   -> A second push after 2 ticks reloads: 3 further ticks.
5. Latch mode: push 0x07, 0x07, 0x09.
   -> NMI triggered on the 1st and 3rd pushes only.
   -> overflow=1 after the 2nd (unread).
   -> snd_dout=0x09 at the end.
6. Reply and reset:
   -> snd_reply_wr 0xC3 -> main_reply=0xC3 next cycle.
   -> Assert reset while 3 entries are queued and NMI is active -> next cycle all outputs 0, main_reply=0.
